// File: rtl/spi_regfile_peripheral.sv
// SPI (mode 0) slave exposing a bank of 8-bit registers.
// Frame: 16 bits MSB first -- R/W (1 = write), 7-bit address, 8-bit data.
// Writes commit when chip select rises; reads stream register data on miso
// during the data phase. Malformed frames pulse frame_err and are dropped.
module spi_regfile_peripheral #(
  parameter int unsigned             NUM_REGS    = 5,
  parameter int unsigned             SYNC_STAGES = 2,
  parameter logic [NUM_REGS*8-1:0]   RESET_VAL   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sclk_raw,
  input  logic                  mosi_raw,
  input  logic                  cs_n_raw,
  output logic                  miso,
  output logic                  miso_oe,
  output logic [NUM_REGS*8-1:0] regs_out,
  output logic [NUM_REGS-1:0]   wr_strobe,
  output logic                  frame_err,
  output logic [7:0]            err_count
);

  localparam int unsigned RW = NUM_REGS * 8;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ADDR  = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic                   sclk_dly_q;
  logic                   cs_dly_q;

  logic sclk_s, mosi_s, cs_s;
  logic sclk_rise, sclk_fall, cs_rise, cs_fall;

  logic [1:0]    state_q, state_d;
  logic [4:0]    cnt_q, cnt_d;
  logic [15:0]   shift_q, shift_d;
  logic [7:0]    tx_q, tx_d;
  logic          oe_q, oe_d;
  logic          first_q, first_d;
  logic [RW-1:0] regs_q, regs_d;
  logic [NUM_REGS-1:0] strobe_q, strobe_d;
  logic          ferr_q, ferr_d;
  logic [7:0]    errcnt_q, errcnt_d;

  logic [15:0] shift_in;
  logic [6:0]  rd_addr;
  logic [6:0]  wr_addr;
  logic        wr_addr_ok;
  logic [7:0]  rd_byte;

  // Synchronisers plus one extra flop on sclk/cs_n for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      cs_sync_q   <= '1;
      sclk_dly_q  <= 1'b0;
      cs_dly_q    <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_raw};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_raw};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n_raw};
      sclk_dly_q  <= sclk_sync_q[SYNC_STAGES-1];
      cs_dly_q    <= cs_sync_q[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_dly_q;
  assign sclk_fall = ~sclk_s & sclk_dly_q;
  assign cs_rise   = cs_s & ~cs_dly_q;
  assign cs_fall   = ~cs_s & cs_dly_q;

  assign shift_in   = {shift_q[14:0], mosi_s};
  assign rd_addr    = shift_in[6:0];
  assign wr_addr    = shift_q[14:8];
  assign wr_addr_ok = 32'(wr_addr) < NUM_REGS;
  // Shifting past the top of the bank yields zero, which doubles as the
  // out-of-range read value.
  assign rd_byte    = 8'(regs_q >> {rd_addr, 3'b000});

  // Frame sequencing, commit/error decision and tx shifter next state.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    oe_d     = oe_q;
    first_d  = first_q;
    regs_d   = regs_q;
    strobe_d = '0;
    ferr_d   = 1'b0;
    errcnt_d = errcnt_q;

    if (cs_rise) begin
      state_d = IDLE;
      cnt_d   = '0;
      oe_d    = 1'b0;
      first_d = 1'b0;
      if (cnt_q == 5'd16) begin
        if (shift_q[15] && wr_addr_ok) begin
          regs_d   = (regs_q & ~(RW'(8'hFF) << {wr_addr, 3'b000}))
                   | (RW'(shift_q[7:0]) << {wr_addr, 3'b000});
          strobe_d = NUM_REGS'(1'b1) << wr_addr;
        end
      end else if (cnt_q != 5'd0) begin
        ferr_d = 1'b1;
        if (errcnt_q != 8'hFF) errcnt_d = errcnt_q + 8'd1;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (cs_fall) begin
            state_d = ADDR;
            cnt_d   = '0;
          end
        end
        ADDR: begin
          if (sclk_rise) begin
            shift_d = shift_in;
            cnt_d   = cnt_q + 5'd1;
            if (cnt_q == 5'd7) begin
              state_d = DATA;
              if (!shift_in[7]) begin
                tx_d    = rd_byte;
                oe_d    = 1'b1;
                first_d = 1'b1;
              end
            end
          end
        end
        DATA: begin
          if (sclk_rise) begin
            shift_d = shift_in;
            cnt_d   = cnt_q + 5'd1;
            if (cnt_q == 5'd15) begin
              state_d = DRAIN;
              oe_d    = 1'b0;
              first_d = 1'b0;
            end
          end else if (sclk_fall && oe_q) begin
            // The 8th falling edge only exposes bit 7; later ones advance.
            if (first_q) first_d = 1'b0;
            else         tx_d    = {tx_q[6:0], 1'b0};
          end
        end
        default: begin
          if (sclk_rise && cnt_q != 5'd17) cnt_d = cnt_q + 5'd1;
        end
      endcase
    end
  end

  // Frame state, register bank and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shift_q  <= '0;
      tx_q     <= '0;
      oe_q     <= 1'b0;
      first_q  <= 1'b0;
      regs_q   <= RESET_VAL;
      strobe_q <= '0;
      ferr_q   <= 1'b0;
      errcnt_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      oe_q     <= oe_d;
      first_q  <= first_d;
      regs_q   <= regs_d;
      strobe_q <= strobe_d;
      ferr_q   <= ferr_d;
      errcnt_q <= errcnt_d;
    end
  end

  assign miso      = oe_q & tx_q[7];
  assign miso_oe   = oe_q;
  assign regs_out  = regs_q;
  assign wr_strobe = strobe_q;
  assign frame_err = ferr_q;
  assign err_count = errcnt_q;

endmodule

// File: tb/tb_spi_regfile_peripheral.sv
// Bench for spi_regfile_peripheral: three instances (default, 1 register,
// 128 registers with a nonzero reset image) sharing clk/rst/sclk/mosi with
// separate chip selects. Directed table, reset-abort, randomized frames
// against a register-array model, and error-counter saturation.
module tb_spi_regfile_peripheral;

  localparam int CLK  = 10;
  localparam int HALF = 50;

  function automatic logic [1023:0] img128();
    logic [1023:0] r;
    r = '0;
    for (int i = 0; i < 128; i++) r[8*i +: 8] = 8'(i) ^ 8'hC3;
    return r;
  endfunction

  localparam logic [1023:0] IMG2 = img128();
  localparam logic [7:0]    IMG1 = 8'h5A;

  logic clk, rst_n, sclk, mosi;
  logic [2:0] cs_n;

  logic [39:0]   ro0;
  logic [7:0]    ro1;
  logic [1023:0] ro2;
  logic [4:0]    st0;
  logic [0:0]    st1;
  logic [127:0]  st2;
  logic [2:0]    mi, oe, fe;
  logic [7:0]    ec0, ec1, ec2;

  spi_regfile_peripheral dut0 (
    .clk(clk), .rst_n(rst_n), .sclk_raw(sclk), .mosi_raw(mosi), .cs_n_raw(cs_n[0]),
    .miso(mi[0]), .miso_oe(oe[0]), .regs_out(ro0), .wr_strobe(st0),
    .frame_err(fe[0]), .err_count(ec0)
  );

  spi_regfile_peripheral #(.NUM_REGS(1), .SYNC_STAGES(3), .RESET_VAL(IMG1)) dut1 (
    .clk(clk), .rst_n(rst_n), .sclk_raw(sclk), .mosi_raw(mosi), .cs_n_raw(cs_n[1]),
    .miso(mi[1]), .miso_oe(oe[1]), .regs_out(ro1), .wr_strobe(st1),
    .frame_err(fe[1]), .err_count(ec1)
  );

  spi_regfile_peripheral #(.NUM_REGS(128), .SYNC_STAGES(2), .RESET_VAL(IMG2)) dut2 (
    .clk(clk), .rst_n(rst_n), .sclk_raw(sclk), .mosi_raw(mosi), .cs_n_raw(cs_n[2]),
    .miso(mi[2]), .miso_oe(oe[2]), .regs_out(ro2), .wr_strobe(st2),
    .frame_err(fe[2]), .err_count(ec2)
  );

  initial clk = 1'b0;
  always #(CLK/2) clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference model: register arrays and error counters per instance.
  int         nreg[3] = '{5, 1, 128};
  logic [7:0] mregs[3][128];
  int         merr[3];

  // Strobe / frame_err activity, sampled on the falling clk edge.
  int           st_cyc[3] = '{0, 0, 0};
  int           fe_cyc[3] = '{0, 0, 0};
  logic [127:0] st_last[3];

  function automatic logic [127:0] get_st(input int d);
    case (d)
      0:       return 128'(st0);
      1:       return 128'(st1);
      default: return st2;
    endcase
  endfunction

  function automatic logic [1023:0] get_ro(input int d);
    case (d)
      0:       return 1024'(ro0);
      1:       return 1024'(ro1);
      default: return ro2;
    endcase
  endfunction

  function automatic logic [7:0] get_ec(input int d);
    case (d)
      0:       return ec0;
      1:       return ec1;
      default: return ec2;
    endcase
  endfunction

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (get_st(d) != '0) begin
        st_cyc[d]  = st_cyc[d] + 1;
        st_last[d] = get_st(d);
      end
      if (fe[d]) fe_cyc[d] = fe_cyc[d] + 1;
    end
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic check_regs(input int d, input string nm);
    logic [1023:0] r;
    int bad;
    r = get_ro(d);
    bad = -1;
    for (int j = nreg[d] - 1; j >= 0; j--)
      if (r[8*j +: 8] !== mregs[d][j]) bad = j;
    total++;
    if (bad < 0) passed++;
    else $display("FAIL %s.regs: reg %0d got %0h expected %0h",
                  nm, bad, r[8*bad +: 8], mregs[d][bad]);
  endtask

  task automatic model_reset();
    for (int j = 0; j < 128; j++) begin
      mregs[0][j] = 8'h00;
      mregs[1][j] = (j == 0) ? IMG1 : 8'h00;
      mregs[2][j] = IMG2[8*j +: 8];
    end
    for (int d = 0; d < 3; d++) merr[d] = 0;
  endtask

  // Frame semantics at transaction level: first 16 bits carry R/W, address, data.
  task automatic model_frame(input int d, input int nb, input logic [31:0] bits,
                             output int wr, output int err, output int rd);
    logic [15:0] w;
    int a;
    w = bits[31:16];
    a = int'(w[14:8]);
    wr = -1; err = 0; rd = -1;
    if (nb >= 9 && !w[15]) rd = (a < nreg[d]) ? int'(mregs[d][a]) : 0;
    if (nb == 16 && w[15] && a < nreg[d]) begin
      mregs[d][a] = w[7:0];
      wr = a;
    end
    if (nb != 0 && nb != 16) begin
      err = 1;
      if (merr[d] < 255) merr[d]++;
    end
  endtask

  // Clocks nb bits into instance d; miso/miso_oe checked just before each rise.
  task automatic run_frame(input string nm, input int d, input int nb,
                           input logic [31:0] bits, input int erd, input bit raise);
    logic [7:0] rb;
    logic exp_oe, exp_mi;
    rb = erd[7:0];
    cs_n[d] = 1'b0;
    #(HALF);
    for (int i = 0; i < nb; i++) begin
      mosi = bits[31-i];
      #(HALF);
      exp_oe = (erd >= 0) && (i >= 8) && (i < 16);
      exp_mi = exp_oe ? rb[15-i] : 1'b0;
      chk($sformatf("%s.oe[%0d]", nm, i), 128'(oe[d]), 128'(exp_oe));
      chk($sformatf("%s.miso[%0d]", nm, i), 128'(mi[d]), 128'(exp_mi));
      sclk = 1'b1;
      #(HALF);
      sclk = 1'b0;
    end
    mosi = 1'b0;
    if (raise) begin
      #(HALF);
      cs_n[d] = 1'b1;
      #(12*CLK);
      chk({nm, ".oe_idle"}, 128'(oe[d]), 128'(1'b0));
      chk({nm, ".miso_idle"}, 128'(mi[d]), 128'(1'b0));
    end
  endtask

  task automatic do_vec(input string nm, input int d, input int nb, input logic [31:0] bits,
                        input int ewr, input int eerr, input int erd, input bit from_model);
    int s0, f0, mwr, merr_f, mrd;
    s0 = st_cyc[d];
    f0 = fe_cyc[d];
    model_frame(d, nb, bits, mwr, merr_f, mrd);
    if (from_model) begin
      ewr = mwr; eerr = merr_f; erd = mrd;
    end
    run_frame(nm, d, nb, bits, erd, 1'b1);
    chk({nm, ".strobe_cycles"}, 128'(st_cyc[d] - s0), 128'((ewr >= 0) ? 1 : 0));
    if (ewr >= 0) chk({nm, ".strobe"}, st_last[d], 128'(1) << ewr);
    chk({nm, ".ferr_cycles"}, 128'(fe_cyc[d] - f0), 128'(eerr));
    chk({nm, ".errcnt"}, 128'(get_ec(d)), 128'(merr[d]));
    check_regs(d, nm);
  endtask

  typedef struct {
    string       nm;
    int          d;
    int          nb;
    logic [31:0] bits;
    int          ewr;
    int          eerr;
    int          erd;
  } vec_t;

  vec_t tbl[19];

  initial begin
    int s0, f0, wr, er, rd, d, nb, a;
    logic [15:0] w;

    tbl[0]  = '{"wr_a0",     0, 16, 32'h80A5_0000,   0, 0,   -1};
    tbl[1]  = '{"wr_a4",     0, 16, 32'h843C_0000,   4, 0,   -1};
    tbl[2]  = '{"rd_a4",     0, 16, 32'h0400_0000,  -1, 0, 'h3C};
    tbl[3]  = '{"wr_oor",    0, 16, 32'h8A11_0000,  -1, 0,   -1};
    tbl[4]  = '{"rd_oor",    0, 16, 32'h0A00_0000,  -1, 0, 'h00};
    tbl[5]  = '{"short12",   0, 12, 32'h8150_0000,  -1, 1,   -1};
    tbl[6]  = '{"long20",    0, 20, 32'h80FF_F000,  -1, 1,   -1};
    tbl[7]  = '{"empty",     0,  0, 32'h0000_0000,  -1, 0,   -1};
    tbl[8]  = '{"rd_a0",     0, 16, 32'h0000_0000,  -1, 0, 'hA5};
    tbl[9]  = '{"d1_rd0",    1, 16, 32'h0000_0000,  -1, 0, 'h5A};
    tbl[10] = '{"d1_wr0",    1, 16, 32'h8033_0000,   0, 0,   -1};
    tbl[11] = '{"d1_rd0b",   1, 16, 32'h0000_0000,  -1, 0, 'h33};
    tbl[12] = '{"d1_wr_oor", 1, 16, 32'h8144_0000,  -1, 0,   -1};
    tbl[13] = '{"d1_rd_oor", 1, 16, 32'h0100_0000,  -1, 0, 'h00};
    tbl[14] = '{"d2_rd127",  2, 16, 32'h7F00_0000,  -1, 0, 'hBC};
    tbl[15] = '{"d2_wr127",  2, 16, 32'hFF96_0000, 127, 0,   -1};
    tbl[16] = '{"d2_rd127b", 2, 16, 32'h7F00_0000,  -1, 0, 'h96};
    tbl[17] = '{"d2_rd5",    2, 16, 32'h0500_0000,  -1, 0, 'hC6};
    tbl[18] = '{"rd_a4b",    0, 16, 32'h0400_0000,  -1, 0, 'h3C};

    rst_n = 1'b0;
    sclk  = 1'b0;
    mosi  = 1'b0;
    cs_n  = 3'b111;
    model_reset();
    #(3*CLK);

    // Values held while reset is asserted.
    for (int i = 0; i < 3; i++) begin
      check_regs(i, $sformatf("reset%0d", i));
      chk($sformatf("reset%0d.strobe", i), get_st(i), '0);
      chk($sformatf("reset%0d.ferr", i), 128'(fe[i]), '0);
      chk($sformatf("reset%0d.miso", i), 128'(mi[i]), '0);
      chk($sformatf("reset%0d.oe", i), 128'(oe[i]), '0);
      chk($sformatf("reset%0d.errcnt", i), 128'(get_ec(i)), '0);
    end
    #(2*CLK);
    rst_n = 1'b1;
    #(5*CLK);

    foreach (tbl[k])
      do_vec(tbl[k].nm, tbl[k].d, tbl[k].nb, tbl[k].bits,
             tbl[k].ewr, tbl[k].eerr, tbl[k].erd, 1'b0);
    chk("errcnt_after_two_errors", 128'(ec0), 128'(8'd2));

    // Reset in the middle of a write frame aborts it.
    s0 = st_cyc[0];
    f0 = fe_cyc[0];
    run_frame("abort", 0, 10, 32'h8177_0000, -1, 1'b0);
    rst_n = 1'b0;
    model_reset();
    #(3*CLK);
    check_regs(0, "abort_in_reset");
    cs_n[0] = 1'b1;
    #(5*CLK);
    rst_n = 1'b1;
    #(10*CLK);
    chk("abort.strobe_cycles", 128'(st_cyc[0] - s0), '0);
    chk("abort.ferr_cycles", 128'(fe_cyc[0] - f0), '0);
    check_regs(0, "abort_after");
    check_regs(2, "abort_d2_image");
    do_vec("after_abort_wr", 0, 16, 32'h8177_0000, 1, 0, -1, 1'b0);
    chk("after_abort_reg1", 128'(ro0[15:8]), 128'(8'h77));

    // Randomized frames against the model.
    for (int k = 0; k < 40; k++) begin
      d  = $urandom_range(0, 2);
      nb = ($urandom_range(0, 9) < 7) ? 16 : $urandom_range(0, 20);
      a  = $urandom_range(0, (nreg[d] + 2 > 127) ? 127 : nreg[d] + 2);
      w  = {1'($urandom_range(0, 1)), 7'(a), 8'($urandom)};
      do_vec($sformatf("rnd%0d", k), d, nb, {w, 16'($urandom)}, 0, 0, 0, 1'b1);
    end

    // Error counter saturates at 255.
    for (int k = 0; k < 260; k++) begin
      model_frame(1, 1, 32'h8000_0000, wr, er, rd);
      run_frame("sat", 1, 1, 32'h8000_0000, -1, 1'b1);
    end
    chk("errcnt_sat", 128'(ec1), 128'(8'd255));
    chk("errcnt_sat_model", 128'(ec1), 128'(merr[1]));
    check_regs(1, "sat");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
